// File: rtl/display_pkg.sv
// Shared types and segment codes for the stopwatch 4-digit multiplexed display.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package display_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0]  seg_t;
  typedef logic [15:0] bcd4_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'h3F;

  localparam seg_t SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/bcd_display_mux_if.sv
// Display-side bundle: packed BCD value and controls in, registered display drive out.
interface bcd_display_mux_if
  import display_pkg::*;
();

  // No handshake: bcd_in/hold/lzb_en are level inputs sampled every clk; the display
  // outputs are registered levels that change only on clk edges.
  bcd4_t      bcd_in;
  logic       hold;
  logic       lzb_en;
  seg_t       seg;
  logic       dp;
  logic [3:0] an;
  logic       digit_err;

  modport master (
    output bcd_in, hold, lzb_en,
    input  seg, dp, an, digit_err
  );

  modport slave (
    input  bcd_in, hold, lzb_en,
    output seg, dp, an, digit_err
  );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to 7-segment decoder; non-decimal nibbles show a dash.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg,
  output logic       invalid
);

  always_comb begin
    seg     = SEG_DASH;
    invalid = 1'b1;
    if (nibble <= 4'd9) begin
      seg     = SEG_DIGIT[nibble];
      invalid = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_display_mux.sv
// Four-digit multiplexed 7-segment driver with frame-aligned snapshot, hold,
// leading-zero blanking, fixed decimal point and inter-digit anti-ghost blanking.
module bcd_display_mux
  import display_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int DP_POS       = 2
) (
  input  logic             clk,
  input  logic             reset,
  bcd_display_mux_if.slave bus
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0] div_cnt;
  logic [1:0]    idx;
  bcd4_t         snap;

  logic       frame_start;
  logic [3:0] nibble;
  seg_t       dec_seg;
  logic       dec_invalid;
  logic [3:0] lead_zero;
  logic       lz_blank;
  logic       in_blank;

  seg_t       seg_d;
  logic       dp_d;
  logic [3:0] an_d;
  logic       err_set;

  assign frame_start = (div_cnt == '0) && (idx == 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      idx     <= 2'd0;
      snap    <= '0;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      // The only snapshot point, so a value never tears mid-frame.
      if (frame_start && !bus.hold) snap <= bus.bcd_in;
    end
  end

  assign nibble = snap[{idx, 2'b00} +: 4];

  seg7_decoder u_dec (
    .nibble  (nibble),
    .seg     (dec_seg),
    .invalid (dec_invalid)
  );

  // lead_zero[k] is set when every nibble from digit 3 down to digit k is zero.
  always_comb begin
    logic run;
    run       = 1'b1;
    lead_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run          = run && (snap[4*k +: 4] == 4'd0);
      lead_zero[k] = run;
    end
  end

  assign lz_blank = bus.lzb_en && (int'(idx) > DP_POS) && (idx != 2'd0) && lead_zero[idx];
  assign in_blank = (div_cnt < BLANK_END);

  always_comb begin
    an_d    = 4'hF;
    seg_d   = SEG_BLANK;
    dp_d    = 1'b1;
    err_set = 1'b0;
    if (!in_blank) begin
      an_d    = ~(4'b0001 << idx);
      dp_d    = (int'(idx) == DP_POS) ? 1'b0 : 1'b1;
      seg_d   = lz_blank ? SEG_BLANK : dec_seg;
      err_set = dec_invalid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.seg       <= SEG_BLANK;
      bus.dp        <= 1'b1;
      bus.an        <= 4'hF;
      bus.digit_err <= 1'b0;
    end else begin
      bus.seg       <= seg_d;
      bus.dp        <= dp_d;
      bus.an        <= an_d;
      bus.digit_err <= bus.digit_err | err_set;
    end
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed plus randomized bench for bcd_display_mux against a cycle-indexed reference model.
module tb_bcd_display_mux;

  localparam int RD  = 8;
  localparam int BC  = 2;
  localparam int DPP = 2;

  logic clk = 1'b0;
  logic reset;

  bcd_display_mux_if bus ();

  bcd_display_mux #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC),
    .DP_POS       (DPP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: t counts clk edges since reset release; slot and digit follow
  // directly from t, and msnap is the value latched at each frame start.
  int          t;
  logic [15:0] msnap;
  logic        merr;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_dp;
  logic [6:0]  codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h t=%0d", tag, obs, exp, t);
  endtask

  task automatic model_reset();
    t     = 0;
    msnap = 16'h0000;
    merr  = 1'b0;
  endtask

  task automatic tick();
    int         cnt;
    int         dig;
    logic [3:0] nib;
    cnt = t % RD;
    dig = (t / RD) % 4;
    nib = msnap[4*dig +: 4];
    if (cnt < BC) begin
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
    end else begin
      exp_an = ~(4'b0001 << dig);
      exp_dp = (dig == DPP) ? 1'b0 : 1'b1;
      if (bus.lzb_en && dig > DPP && (msnap >> (4*dig)) == 16'd0)
        exp_seg = 7'h7F;
      else if (nib <= 4'd9)
        exp_seg = codes[nib];
      else begin
        exp_seg = 7'h3F;
        merr    = 1'b1;
      end
    end
    if (t % (4*RD) == 0 && !bus.hold) msnap = bus.bcd_in;
    t++;
    @(posedge clk);
    @(negedge clk);
    check("an",  {12'd0, bus.an},        {12'd0, exp_an});
    check("seg", {9'd0, bus.seg},        {9'd0, exp_seg});
    check("dp",  {15'd0, bus.dp},        {15'd0, exp_dp});
    check("err", {15'd0, bus.digit_err}, {15'd0, merr});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"},  {12'd0, bus.an},        16'h000F);
    check({tag, "_seg"}, {9'd0, bus.seg},        16'h007F);
    check({tag, "_dp"},  {15'd0, bus.dp},        16'h0001);
    check({tag, "_err"}, {15'd0, bus.digit_err}, 16'h0000);
  endtask

  function automatic logic [15:0] rand_bcd(input bit allow_bad);
    logic [15:0] v;
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 2) == 0) v[4*k +: 4] = 4'd0;
      else                           v[4*k +: 4] = 4'($urandom_range(0, 9));
    end
    if (allow_bad && $urandom_range(0, 9) == 0)
      v[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  initial begin
    reset      = 1'b1;
    bus.bcd_in = 16'h0000;
    bus.hold   = 1'b0;
    bus.lzb_en = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Plain scan of 1234 with no blanking
    bus.bcd_in = 16'h1234;
    ticks(70);

    // Asynchronous reset while digit 2 (an=B) is lit
    while (t % (4*RD) != 2*RD + 5) tick();
    check("pre_reset_an", {12'd0, bus.an}, 16'h000B);
    reset = 1'b1;
    #1;
    check_reset_outputs("async");
    @(negedge clk);
    check_reset_outputs("held");
    reset = 1'b0;
    model_reset();

    // Leading-zero blanking
    bus.bcd_in = 16'h0056;
    bus.lzb_en = 1'b1;
    ticks(70);
    bus.bcd_in = 16'h0000;
    ticks(70);

    // Hold freezes 0042 across several frames
    bus.lzb_en = 1'b0;
    bus.bcd_in = 16'h0042;
    ticks(40);
    bus.hold   = 1'b1;
    bus.bcd_in = 16'h0099;
    ticks(3*4*RD + 5);
    bus.hold = 1'b0;
    ticks(70);

    // Mid-frame change while idx=2 waits for the next frame start
    bus.bcd_in = 16'h1111;
    ticks(40);
    while (t % (4*RD) != 2*RD + 3) tick();
    bus.bcd_in = 16'h2222;
    ticks(50);

    // Invalid nibble sets sticky error
    bus.bcd_in = 16'h00A1;
    ticks(40);
    bus.bcd_in = 16'h0001;
    ticks(70);
    check("err_sticky", {15'd0, bus.digit_err}, 16'h0001);

    // Randomized traffic after a fresh reset
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst2");
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < 60; n++) begin
      bus.bcd_in = rand_bcd(n > 40);
      bus.hold   = ($urandom_range(0, 3) == 0);
      bus.lzb_en = 1'($urandom_range(0, 1));
      ticks($urandom_range(5, 45));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
